// File: rtl/ysyx_branch_pkg.sv
// Shared encodings for the branch/jump resolution sequencer.
// Optional statistics counters are enabled with YSYX_BRANCH_STATS_EN.
package ysyx_branch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JUMP = 3'b001,
        BR_EQ   = 3'b010,
        BR_NE   = 3'b011,
        BR_LT   = 3'b100,
        BR_GE   = 3'b101,
        BR_LTU  = 3'b110,
        BR_GEU  = 3'b111
    } br_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESOLVE  = 2'd1,
        REDIRECT = 2'd2,
        EXC      = 2'd3
    } br_state_e;

    // Instruction fetch needs 4-byte alignment; anything else traps.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_branch_cmp.sv
// Combinational branch condition evaluator; none/jump encodings yield 0.
module ysyx_branch_cmp
    import ysyx_branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  br_type_e        type_i,
    output logic            cmp_result_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_i == rs2_i);
    assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u = (rs1_i < rs2_i);

    always_comb begin
        cmp_result_o = 1'b0;
        case (type_i)
            BR_EQ:   cmp_result_o = eq;
            BR_NE:   cmp_result_o = !eq;
            BR_LT:   cmp_result_o = lt_s;
            BR_GE:   cmp_result_o = !lt_s;
            BR_LTU:  cmp_result_o = lt_u;
            BR_GEU:  cmp_result_o = !lt_u;
            default: cmp_result_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_branch_ctrl.sv
// Branch/jump resolution sequencer owning the fetch PC; one op in flight.
// Define YSYX_BRANCH_STATS_EN to add the stat_resolved/stat_taken counters.
module ysyx_branch_ctrl
    import ysyx_branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_type,
    input  logic            in_jalr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic            npc_valid,
    input  logic            npc_ready,
    output logic [XLEN-1:0] npc,
    output logic            flush,
    output logic [XLEN-1:0] link_data,
    output logic            exc_valid,
    output logic [XLEN-1:0] exc_tval,
    input  logic            exc_ack,
    output logic [1:0]      dbg_state_o,
    output logic [XLEN-1:0] pc_o
`ifdef YSYX_BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_resolved,
    output logic [31:0]     stat_taken
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; once valid rises its payload holds until that transfer.

    br_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] op_pc_q, op_pc_d;
    br_type_e        op_type_q, op_type_d;
    logic            op_jalr_q, op_jalr_d;
    logic [XLEN-1:0] op_rs1_q, op_rs1_d;
    logic [XLEN-1:0] op_rs2_q, op_rs2_d;
    logic [XLEN-1:0] op_imm_q, op_imm_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] link_q, link_d;
    logic [XLEN-1:0] tval_q, tval_d;

    logic            cmp_result;
    logic            taken;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;

    ysyx_branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .rs1_i        (op_rs1_q),
        .rs2_i        (op_rs2_q),
        .type_i       (op_type_q),
        .cmp_result_o (cmp_result)
    );

    assign taken  = (op_type_q == BR_JUMP) | cmp_result;
    assign seq_pc = op_pc_q + XLEN'(4);
    // Additions wrap at XLEN bits; jalr clears bit 0 of its sum.
    assign target = (op_type_q == BR_JUMP && op_jalr_q)
                  ? ((op_rs1_q + op_imm_q) & ~XLEN'(1))
                  : (op_pc_q + op_imm_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_pc_d   = op_pc_q;
        op_type_d = op_type_q;
        op_jalr_d = op_jalr_q;
        op_rs1_d  = op_rs1_q;
        op_rs2_d  = op_rs2_q;
        op_imm_d  = op_imm_q;
        npc_d     = npc_q;
        flush_d   = flush_q;
        link_d    = link_q;
        tval_d    = tval_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_pc_d   = in_pc;
                    op_type_d = br_type_e'(in_type);
                    op_jalr_d = in_jalr;
                    op_rs1_d  = in_rs1;
                    op_rs2_d  = in_rs2;
                    op_imm_d  = in_imm;
                    state_d   = RESOLVE;
                end
            end
            RESOLVE: begin
                // Only a taken op can fault; a not-taken branch falls through.
                if (taken && is_misaligned(target)) begin
                    tval_d  = target;
                    state_d = EXC;
                end else begin
                    npc_d   = taken ? target : seq_pc;
                    flush_d = taken;
                    link_d  = seq_pc;
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (npc_ready) begin
                    pc_d    = npc_q;
                    state_d = IDLE;
                end
            end
            EXC: begin
                if (exc_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            op_pc_q   <= '0;
            op_type_q <= BR_NONE;
            op_jalr_q <= 1'b0;
            op_rs1_q  <= '0;
            op_rs2_q  <= '0;
            op_imm_q  <= '0;
            npc_q     <= '0;
            flush_q   <= 1'b0;
            link_q    <= '0;
            tval_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_pc_q   <= op_pc_d;
            op_type_q <= op_type_d;
            op_jalr_q <= op_jalr_d;
            op_rs1_q  <= op_rs1_d;
            op_rs2_q  <= op_rs2_d;
            op_imm_q  <= op_imm_d;
            npc_q     <= npc_d;
            flush_q   <= flush_d;
            link_q    <= link_d;
            tval_q    <= tval_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign npc_valid   = (state_q == REDIRECT);
    assign npc         = npc_q;
    assign flush       = flush_q && (state_q == REDIRECT);
    assign link_data   = link_q;
    assign exc_valid   = (state_q == EXC);
    assign exc_tval    = tval_q;
    assign pc_o        = pc_q;
    assign dbg_state_o = state_q;

`ifdef YSYX_BRANCH_STATS_EN
    logic [31:0] stat_resolved_q;
    logic [31:0] stat_taken_q;
    logic        beat_done;

    assign beat_done = (state_q == REDIRECT) && npc_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved_q <= '0;
            stat_taken_q    <= '0;
        end else if (beat_done) begin
            if (stat_resolved_q != 32'hFFFF_FFFF) begin
                stat_resolved_q <= stat_resolved_q + 32'd1;
            end
            if (flush_q && stat_taken_q != 32'hFFFF_FFFF) begin
                stat_taken_q <= stat_taken_q + 32'd1;
            end
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_taken    = stat_taken_q;
`endif

endmodule
